// File: rtl/sprite_pkg.sv
// Shared definitions for the VGA sprite path: descriptor layout, coordinate width
// and the per-line scheduler state encoding.
package sprite_pkg;

  localparam int COORD_W      = 19;
  localparam int SCREEN_H_DEF = 480;
  localparam int DESC_W       = 64;
  localparam int FIELD_W      = 16;

  // Descriptor bit offsets: {X, bottom Y, width, height}
  localparam int X_LSB = 48;
  localparam int Y_LSB = 32;
  localparam int W_LSB = 16;
  localparam int H_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sprite_vspan_check.sv
// Combinational vertical-overlap test of one sprite descriptor against a row
// expressed in the Y-up coordinate system (strict compares on both edges).
import sprite_pkg::*;

module sprite_vspan_check (
  input  logic [COORD_W-1:0] ty,
  input  logic [DESC_W-1:0]  desc,
  output logic               hit
);

  logic [COORD_W-1:0] y_bot;
  logic [COORD_W-1:0] y_top;
  logic               unused_x;

  // Bottom Y plus height cannot exceed 17 bits, so the 19-bit sum never wraps
  assign y_bot = COORD_W'(desc[Y_LSB +: FIELD_W]);
  assign y_top = y_bot + COORD_W'(desc[H_LSB +: FIELD_W]);

  assign hit = (desc[W_LSB +: FIELD_W] != '0) && (ty > y_bot) && (ty < y_top);

  // X belongs to the horizontal per-pixel test, not the vertical span
  assign unused_x = ^desc[X_LSB +: FIELD_W];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: walks the sprite table once per line_start and
// writes the indices of vertically overlapping sprites into the active list.
import sprite_pkg::*;

module sprite_line_scheduler #(
  parameter  int NUM_SPRITES = 8,
  parameter  int MAX_ACTIVE  = 4,
  parameter  int SCREEN_H    = SCREEN_H_DEF,
  localparam int AW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int IW = (MAX_ACTIVE > 1) ? $clog2(MAX_ACTIVE) : 1,
  localparam int CW = $clog2(MAX_ACTIVE + 1)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               line_start,
  input  logic [COORD_W-1:0] line_y,
  output logic               tbl_rd_en,
  output logic [AW-1:0]      tbl_addr,
  input  logic [DESC_W-1:0]  tbl_data,
  output logic               act_wr_en,
  output logic [IW-1:0]      act_wr_idx,
  output logic [AW-1:0]      act_wr_data,
  output logic [CW-1:0]      act_count,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SPRITES - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_ACTIVE);

  state_t             state;
  state_t             next_state;
  logic [AW-1:0]      idx;
  logic [AW-1:0]      eval_idx;
  logic [AW-1:0]      hit_idx;
  logic [COORD_W-1:0] ty;
  logic               drain_phase;
  logic               rd_valid;
  logic               hit_q;
  logic               span_hit;

  sprite_vspan_check u_vspan (
    .ty   (ty),
    .desc (tbl_data),
    .hit  (span_hit)
  );

  assign tbl_rd_en   = (state == SCAN);
  assign tbl_addr    = tbl_rd_en ? idx : '0;
  assign busy        = (state == SCAN) || (state == DRAIN);
  assign done        = (state == DONE);
  // A new line_start discards any hit still waiting to be written
  assign act_wr_en   = hit_q && (act_count < MAX_CNT) && !line_start;
  assign act_wr_idx  = IW'(act_count);
  assign act_wr_data = hit_idx;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = IDLE;
      SCAN:    if (idx == LAST_IDX) next_state = DRAIN;
      DRAIN:   if (drain_phase) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (line_start) next_state = SCAN;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      idx         <= '0;
      eval_idx    <= '0;
      hit_idx     <= '0;
      ty          <= '0;
      drain_phase <= 1'b0;
      rd_valid    <= 1'b0;
      hit_q       <= 1'b0;
      act_count   <= '0;
      overflow    <= 1'b0;
    end else begin
      state    <= next_state;
      rd_valid <= tbl_rd_en;
      eval_idx <= idx;
      hit_q    <= rd_valid && span_hit;
      hit_idx  <= eval_idx;

      if (state == SCAN) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + AW'(1);
      end
      // DRAIN lasts two cycles: evaluate the last entry, then write it
      drain_phase <= (state == DRAIN) ? ~drain_phase : 1'b0;

      if (act_wr_en) act_count <= act_count + CW'(1);
      if (hit_q && (act_count == MAX_CNT)) overflow <= 1'b1;

      if (line_start) begin
        ty          <= COORD_W'(SCREEN_H) - line_y;
        idx         <= '0;
        drain_phase <= 1'b0;
        rd_valid    <= 1'b0;
        hit_q       <= 1'b0;
        act_count   <= '0;
        overflow    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler: directed cases plus random tables,
// checked cycle by cycle against a list-based model of the scan schedule.
module tb_sprite_line_scheduler;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int SH = 480;

  logic        clock = 1'b0;
  logic        resetn;
  logic        line_start;
  logic [18:0] line_y;
  logic        tbl_rd_en;
  logic [2:0]  tbl_addr;
  logic [63:0] tbl_data;
  logic        act_wr_en;
  logic [1:0]  act_wr_idx;
  logic [2:0]  act_wr_data;
  logic [2:0]  act_count;
  logic        overflow;
  logic        busy;
  logic        done;

  logic [63:0] mem [N];
  int total = 0;
  int bad   = 0;

  sprite_line_scheduler #(
    .NUM_SPRITES (N),
    .MAX_ACTIVE  (M),
    .SCREEN_H    (SH)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .line_start  (line_start),
    .line_y      (line_y),
    .tbl_rd_en   (tbl_rd_en),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .act_wr_en   (act_wr_en),
    .act_wr_idx  (act_wr_idx),
    .act_wr_data (act_wr_data),
    .act_count   (act_count),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Sprite table RAM: one-cycle read latency
  always @(posedge clock) begin
    if (tbl_rd_en) tbl_data <= mem[tbl_addr];
  end

  function automatic logic [63:0] make_desc(input int x, input int y, input int w, input int h);
    logic [15:0] fx, fy, fw, fh;
    fx = 16'(x); fy = 16'(y); fw = 16'(w); fh = 16'(h);
    return {fx, fy, fw, fh};
  endfunction

  function automatic bit model_hit(input int ty, input logic [63:0] d);
    int yb, w, h;
    yb = int'(d[47:32]);
    w  = int'(d[31:16]);
    h  = int'(d[15:0]);
    return (w != 0) && (ty > yb) && (ty < yb + h);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulses line_start for one cycle; returns positioned in cycle 1 of the scan
  task automatic apply_stimulus(input logic [18:0] y);
    line_y     = y;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    line_y     = 19'($urandom);
  endtask

  task automatic check_idle_zero(input string tag);
    check_output({tag, "_rd_en"}, 32'(tbl_rd_en), 0);
    check_output({tag, "_addr"},  32'(tbl_addr), 0);
    check_output({tag, "_wr_en"}, 32'(act_wr_en), 0);
    check_output({tag, "_wr_idx"}, 32'(act_wr_idx), 0);
    check_output({tag, "_wr_data"}, 32'(act_wr_data), 0);
    check_output({tag, "_count"}, 32'(act_count), 0);
    check_output({tag, "_ovf"},   32'(overflow), 0);
    check_output({tag, "_busy"},  32'(busy), 0);
    check_output({tag, "_done"},  32'(done), 0);
  endtask

  // Checks cycles 1..N+4 of a scan of line y against the current table
  task automatic check_scan(input string tag, input logic [18:0] y);
    int hits[$];
    int ty;
    bit exp_wr;
    int exp_idx, exp_data, exp_cnt;
    bit exp_ovf;
    ty = (SH - int'(y)) & 32'h7FFFF;
    for (int k = 0; k < N; k++) if (model_hit(ty, mem[k])) hits.push_back(k);
    for (int c = 1; c <= N + 4; c++) begin
      exp_wr = 0; exp_idx = 0; exp_data = 0; exp_cnt = 0;
      for (int j = 0; j < hits.size() && j < M; j++) begin
        if (hits[j] + 3 == c) begin exp_wr = 1; exp_idx = j; exp_data = hits[j]; end
        if (hits[j] + 3 < c) exp_cnt++;
      end
      exp_ovf = (hits.size() > M) && (hits[M] + 3 < c);
      check_output({tag, "_rd_en"}, 32'(tbl_rd_en), 32'(c <= N));
      check_output({tag, "_addr"},  32'(tbl_addr), (c <= N) ? 32'(c - 1) : 0);
      check_output({tag, "_busy"},  32'(busy), 32'(c <= N + 2));
      check_output({tag, "_done"},  32'(done), 32'(c == N + 3));
      check_output({tag, "_wr_en"}, 32'(act_wr_en), 32'(exp_wr));
      if (exp_wr) begin
        check_output({tag, "_wr_idx"},  32'(act_wr_idx), 32'(exp_idx));
        check_output({tag, "_wr_data"}, 32'(act_wr_data), 32'(exp_data));
      end
      check_output({tag, "_count"}, 32'(act_count), 32'(exp_cnt));
      check_output({tag, "_ovf"},   32'(overflow), 32'(exp_ovf));
      tick();
    end
  endtask

  task automatic clear_table();
    for (int k = 0; k < N; k++) mem[k] = make_desc(k * 10, 0, 8, 0);
  endtask

  initial begin
    resetn     = 1'b0;
    line_start = 1'b0;
    line_y     = '0;
    tbl_data   = '0;
    clear_table();
    repeat (3) tick();
    resetn = 1'b1;

    $display("[TB] idle after reset");
    for (int c = 0; c < 20; c++) begin
      check_idle_zero("rst_idle");
      tick();
    end

    $display("[TB] single hit");
    clear_table();
    mem[2] = make_desc(40, 50, 16, 100);
    apply_stimulus(19'd380);
    check_scan("single", 19'd380);

    $display("[TB] strict edges");
    clear_table();
    mem[0] = make_desc(0, 100, 4, 10);
    mem[1] = make_desc(0, 90, 4, 10);
    mem[2] = make_desc(0, 99, 4, 2);
    apply_stimulus(19'd380);
    check_scan("edges", 19'd380);

    $display("[TB] overflow then clear");
    for (int k = 0; k < N; k++) mem[k] = make_desc(k, 0, 5, 200);
    apply_stimulus(19'd380);
    check_scan("ovf", 19'd380);
    check_output("ovf_hold_count", 32'(act_count), 4);
    check_output("ovf_hold_flag", 32'(overflow), 1);
    apply_stimulus(19'd0);
    check_scan("ovf_clear", 19'd0);

    $display("[TB] restart mid-scan");
    clear_table();
    mem[0] = make_desc(0, 0, 3, 50);
    mem[1] = make_desc(0, 5, 3, 10);
    mem[5] = make_desc(0, 200, 3, 50);
    apply_stimulus(19'd470);
    for (int c = 1; c <= 3; c++) begin
      check_output("abort_busy", 32'(busy), 1);
      check_output("abort_done", 32'(done), 0);
      check_output("abort_addr", 32'(tbl_addr), 32'(c - 1));
      tick();
    end
    check_output("abort_c4_addr", 32'(tbl_addr), 3);
    apply_stimulus(19'd260);
    check_scan("restart", 19'd260);

    $display("[TB] reset mid-scan");
    for (int k = 0; k < N; k++) mem[k] = make_desc(k, 0, 5, 200);
    apply_stimulus(19'd380);
    repeat (4) tick();
    check_output("rstmid_c5_busy", 32'(busy), 1);
    resetn = 1'b0;
    tick();
    check_idle_zero("rstmid");
    resetn = 1'b1;
    for (int c = 0; c < N + 4; c++) begin
      check_output("rstmid_after_done", 32'(done), 0);
      check_output("rstmid_after_busy", 32'(busy), 0);
      tick();
    end

    $display("[TB] random tables");
    for (int it = 0; it < 16; it++) begin
      logic [18:0] y;
      for (int k = 0; k < N; k++) begin
        mem[k] = make_desc(int'($urandom_range(0, 639)),
                           int'($urandom_range(0, 479)),
                           ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 64)),
                           ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 300)));
      end
      y = 19'($urandom_range(0, 480));
      apply_stimulus(y);
      check_scan("rand", y);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
